// File: rtl/led_pkg.sv
// Shared types and sizes for the LED serial link receiver.
package led_pkg;
   localparam int NZONE      = 16;
   localparam int CW         = 4;
   localparam int FRAME_BITS = NZONE * 3 * CW;

   typedef struct packed {
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } zone_rgb_t;

   typedef enum logic [1:0] {IDLE, RECV, WAIT_GAP} rx_state_e;
endpackage

// File: rtl/led_rx_sync.sv
// Brings cko/sdo into the clk_fast domain and flags cko rising edges.
module led_rx_sync (
   input  logic clk_fast,
   input  logic rstn,
   input  logic cko_i,
   input  logic sdo_i,
   output logic rise,
   output logic sdo_s
);
   logic [2:0] cko_q;
   logic [1:0] sdo_q;

   // rise and sdo_s are registered together, so sdo_s is the s2 sample
   // taken in the same cycle as the cko edge.
   always_ff @(posedge clk_fast or negedge rstn) begin
      if (!rstn) begin
         cko_q <= '0;
         sdo_q <= '0;
         rise  <= 1'b0;
         sdo_s <= 1'b0;
      end else begin
         cko_q <= {cko_q[1:0], cko_i};
         sdo_q <= {sdo_q[0], sdo_i};
         rise  <= cko_q[1] & ~cko_q[2];
         sdo_s <= sdo_q[1];
      end
   end
endmodule

// File: rtl/led_serial_rx.sv
// LED serial link decoder: rebuilds one frame of NZONE x 12-bit RGB zones from cko/sdo.
module led_serial_rx #(
   parameter int NZONE   = 16,
   parameter int GAP_CYC = 64,
   parameter int CNT_W   = 16
) (
   input  logic                              clk_fast,
   input  logic                              rstn,
   input  logic                              cko_i,
   input  logic                              sdo_i,
   output logic [NZONE-1:0][led_pkg::CW-1:0] mean_r,
   output logic [NZONE-1:0][led_pkg::CW-1:0] mean_g,
   output logic [NZONE-1:0][led_pkg::CW-1:0] mean_b,
   output logic                              frame_valid,
   output logic                              frame_err,
   output logic [CNT_W-1:0]                  frame_cnt
);
   import led_pkg::*;

   localparam int ZW    = 3 * CW;
   localparam int FBITS = NZONE * ZW;
   localparam int BCW   = $clog2(FBITS + 1);
   localparam int GTW   = $clog2(GAP_CYC + 1);

   logic                  rise, sdo_s, gap, ovl_seen;
   rx_state_e             state;
   logic [FBITS-1:0]      shreg;
   logic [BCW-1:0]        bit_cnt;
   logic [GTW-1:0]        gap_tmr;
   zone_rgb_t [NZONE-1:0] zones;

   led_rx_sync u_sync (
      .clk_fast (clk_fast),
      .rstn     (rstn),
      .cko_i    (cko_i),
      .sdo_i    (sdo_i),
      .rise     (rise),
      .sdo_s    (sdo_s)
   );

   // Zone 0 is shifted in first, so it ends up in the top slice.
   assign zones = shreg;
   assign gap   = (gap_tmr == GTW'(GAP_CYC - 1)) & ~rise;

   always_ff @(posedge clk_fast or negedge rstn) begin
      if (!rstn)                           gap_tmr <= '0;
      else if (rise)                       gap_tmr <= '0;
      else if (gap_tmr != GTW'(GAP_CYC))   gap_tmr <= gap_tmr + 1'b1;
   end

   always_ff @(posedge clk_fast or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         ovl_seen    <= 1'b0;
         mean_r      <= '0;
         mean_g      <= '0;
         mean_b      <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            IDLE: if (rise) begin
               shreg   <= {shreg[FBITS-2:0], sdo_s};
               bit_cnt <= BCW'(1);
               state   <= RECV;
            end
            RECV: begin
               // A complete frame wins over any later rise or gap.
               if (bit_cnt == BCW'(FBITS)) begin
                  for (int k = 0; k < NZONE; k++) begin
                     mean_r[k] <= zones[NZONE-1-k].r;
                     mean_g[k] <= zones[NZONE-1-k].g;
                     mean_b[k] <= zones[NZONE-1-k].b;
                  end
                  frame_valid <= 1'b1;
                  frame_cnt   <= frame_cnt + 1'b1;
                  ovl_seen    <= 1'b0;
                  state       <= WAIT_GAP;
               end else if (rise) begin
                  shreg   <= {shreg[FBITS-2:0], sdo_s};
                  bit_cnt <= bit_cnt + 1'b1;
               end else if (gap) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end
            end
            WAIT_GAP: begin
               if (gap) begin
                  state <= IDLE;
               end else if (rise && !ovl_seen) begin
                  frame_err <= 1'b1;
                  ovl_seen  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_led_serial_rx.sv
// Self-checking bench for led_serial_rx: table of frame shapes plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_led_serial_rx;
   localparam int NZ   = 16;
   localparam int GAP  = 64;
   localparam int FB   = NZ * 12;
   localparam int MAXB = 256;

   logic clk_fast = 1'b0, rstn = 1'b0, cko_i = 1'b0, sdo_i = 1'b0;
   logic [NZ-1:0][3:0] mean_r, mean_g, mean_b, wr, wg, wb;
   logic               frame_valid, frame_err, wv, we;
   logic [15:0]        frame_cnt;
   logic [1:0]         wcnt;

   led_serial_rx #(.NZONE(NZ), .GAP_CYC(GAP), .CNT_W(16)) dut (
      .clk_fast(clk_fast), .rstn(rstn), .cko_i(cko_i), .sdo_i(sdo_i),
      .mean_r(mean_r), .mean_g(mean_g), .mean_b(mean_b),
      .frame_valid(frame_valid), .frame_err(frame_err), .frame_cnt(frame_cnt));

   // Narrow counter copy: exercises frame_cnt wrap without 65536 frames.
   led_serial_rx #(.NZONE(NZ), .GAP_CYC(GAP), .CNT_W(2)) dutw (
      .clk_fast(clk_fast), .rstn(rstn), .cko_i(cko_i), .sdo_i(sdo_i),
      .mean_r(wr), .mean_g(wg), .mean_b(wb),
      .frame_valid(wv), .frame_err(we), .frame_cnt(wcnt));

   always #3.333 clk_fast = ~clk_fast;

   int pcnt = 0;
   always @(posedge clk_fast) pcnt++;

   int fv_n, fe_n, wv_n, we_n, fv_pc, fe_pc;
   int rise_pc [MAXB];
   always @(negedge clk_fast) begin
      if (frame_valid) begin if (fv_n == 0) fv_pc = pcnt; fv_n++; end
      if (frame_err)   begin if (fe_n == 0) fe_pc = pcnt; fe_n++; end
      if (wv) wv_n++;
      if (we) we_n++;
   end

   int n_vec = 0, n_bad = 0;
   logic [NZ-1:0][3:0] exp_r, exp_g, exp_b;
   int exp_cnt;

   typedef struct {
      string name;
      int    nb;
      int    ev;
      int    ee;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clr_mon();
      fv_n = 0; fe_n = 0; wv_n = 0; we_n = 0; fv_pc = -1; fe_pc = -1;
   endtask

   // Reference: frame bit i is the i-th bit on the wire; zone k = bits 12k..12k+11 as R,G,B MSB first.
   task automatic model_latch(input logic [MAXB-1:0] bits);
      for (int k = 0; k < NZ; k++)
         for (int j = 0; j < 4; j++) begin
            exp_r[k][3-j] = bits[12*k + j];
            exp_g[k][3-j] = bits[12*k + 4 + j];
            exp_b[k][3-j] = bits[12*k + 8 + j];
         end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_fast);
   endtask

   // lo/hi = 0 picks random phase lengths in 3..8 cycles.
   task automatic send_bit(input logic b, input int idx, input int lo, input int hi);
      @(negedge clk_fast);
      sdo_i = b;
      repeat (lo > 0 ? lo : $urandom_range(3, 8)) @(negedge clk_fast);
      cko_i = 1'b1;
      if (idx < MAXB) rise_pc[idx] = pcnt + 1;
      repeat (hi > 0 ? hi : $urandom_range(3, 8)) @(negedge clk_fast);
      cko_i = 1'b0;
   endtask

   task automatic send_bits(input logic [MAXB-1:0] bits, input int first, input int last,
                            input int lo, input int hi);
      for (int i = first; i < last; i++) send_bit(bits[i], i, lo, hi);
   endtask

   function automatic logic [MAXB-1:0] rand_bits();
      logic [MAXB-1:0] b;
      for (int w = 0; w < MAXB / 32; w++) b[w*32 +: 32] = $urandom();
      return b;
   endfunction

   task automatic chk_outputs(input string nm);
      chk({nm, ":mean_r"}, mean_r, exp_r);
      chk({nm, ":mean_g"}, mean_g, exp_g);
      chk({nm, ":mean_b"}, mean_b, exp_b);
      chk({nm, ":frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt & 16'hFFFF));
      chk({nm, ":w_cnt"}, 64'(wcnt), 64'(exp_cnt & 3));
      chk({nm, ":w_mean_r"}, wr, exp_r);
      chk({nm, ":w_mean_g"}, wg, exp_g);
      chk({nm, ":w_mean_b"}, wb, exp_b);
   endtask

   task automatic run_vec(input vec_t v, input logic [MAXB-1:0] bits, input int lo, input int hi);
      clr_mon();
      send_bits(bits, 0, v.nb, lo, hi);
      idle(GAP + 12);
      if (v.nb >= FB) begin model_latch(bits); exp_cnt++; end
      chk({v.name, ":valid_n"}, 64'(fv_n), 64'(v.ev));
      chk({v.name, ":err_n"}, 64'(fe_n), 64'(v.ee));
      chk({v.name, ":w_valid_n"}, 64'(wv_n), 64'(v.ev));
      chk({v.name, ":w_err_n"}, 64'(we_n), 64'(v.ee));
      if (v.ev != 0) chk({v.name, ":valid_lat"}, 64'(fv_pc), 64'(rise_pc[FB-1] + 4));
      if (v.ee != 0)
         chk({v.name, ":err_lat"}, 64'(fe_pc),
             64'((v.nb > FB) ? rise_pc[FB] + 3 : rise_pc[v.nb-1] + 3 + GAP));
      chk_outputs(v.name);
   endtask

   initial begin
      logic [MAXB-1:0] bits;
      logic [11:0]     zv;

      tbl[0] = '{"good_spec",   192, 1, 0};
      tbl[1] = '{"short100",    100, 0, 1};
      tbl[2] = '{"good_rand",   192, 1, 0};
      tbl[3] = '{"overlong200", 200, 1, 1};
      tbl[4] = '{"short191",    191, 0, 1};
      tbl[5] = '{"over193",     193, 1, 1};
      tbl[6] = '{"short1",        1, 0, 1};
      tbl[7] = '{"good_rand2",  192, 1, 0};
      exp_r = '0; exp_g = '0; exp_b = '0; exp_cnt = 0;
      clr_mon();

      // Reset held with cko toggling
      rstn = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cko_i = ~cko_i; sdo_i = i[0];
         idle(4);
      end
      cko_i = 1'b0;
      chk("rst:frame_valid", 64'(frame_valid), 64'(0));
      chk("rst:frame_err", 64'(frame_err), 64'(0));
      chk_outputs("rst");
      idle(3);
      rstn = 1'b1;
      idle(GAP + 8);
      chk("rst:no_pulses", 64'(fv_n + fe_n), 64'(0));

      for (int t = 0; t < 8; t++) begin
         bits = rand_bits();
         if (t == 0) begin
            zv = 12'hdbb; for (int j = 0; j < 12; j++) bits[j] = zv[11-j];
            zv = 12'h742; for (int j = 0; j < 12; j++) bits[180 + j] = zv[11-j];
            run_vec(tbl[t], bits, 7, 8);
            chk("spec:r0", 64'(mean_r[0]), 64'(4'hd));
            chk("spec:g0", 64'(mean_g[0]), 64'(4'hb));
            chk("spec:b0", 64'(mean_b[0]), 64'(4'hb));
            chk("spec:r15", 64'(mean_r[15]), 64'(4'h7));
            chk("spec:b15", 64'(mean_b[15]), 64'(4'h2));
            chk("spec:cnt", 64'(frame_cnt), 64'(1));
         end else begin
            run_vec(tbl[t], bits, 0, 0);
         end
      end

      // Mid-frame reset after 50 bits; remainder decodes as a short frame.
      bits = rand_bits();
      clr_mon();
      send_bits(bits, 0, 50, 0, 0);
      @(negedge clk_fast);
      rstn = 1'b0;
      #1;
      exp_r = '0; exp_g = '0; exp_b = '0; exp_cnt = 0;
      chk("midrst:frame_valid", 64'(frame_valid), 64'(0));
      chk_outputs("midrst_low");
      idle(5);
      rstn = 1'b1;
      clr_mon();
      send_bits(bits, 50, FB, 0, 0);
      idle(GAP + 12);
      chk("midrst:valid_n", 64'(fv_n), 64'(0));
      chk("midrst:err_n", 64'(fe_n), 64'(1));
      chk("midrst:err_lat", 64'(fe_pc), 64'(rise_pc[FB-1] + 3 + GAP));
      chk_outputs("midrst_tail");
      bits = rand_bits();
      run_vec('{"after_rst", 192, 1, 0}, bits, 0, 0);

      // Back-to-back frames separated by GAP+2 idle cycles.
      clr_mon();
      for (int f = 0; f < 3; f++) begin
         bits = rand_bits();
         send_bits(bits, 0, FB, 0, 0);
         model_latch(bits);
         exp_cnt++;
         idle(GAP + 2);
      end
      idle(12);
      chk("b2b:valid_n", 64'(fv_n), 64'(3));
      chk("b2b:err_n", 64'(fe_n), 64'(0));
      chk("b2b:w_valid_n", 64'(wv_n), 64'(3));
      chk_outputs("b2b");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
